// File: rtl/fpu_pkg.sv
// Shared constants, classes and stage-register layouts for the pipelined
// binary32 adder/subtractor.
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]      MAXF    = 32'h7F7F_FFFF;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;
  typedef enum logic [1:0] {SPC_NONE, SPC_NAN, SPC_INF, SPC_ZERO} spc_e;

  // Aligned operands: A has the larger magnitude, B is pre-shifted into {man,G,R,S}
  typedef struct packed {
    logic             sign_a;
    logic             sign_b;
    logic [EXP_W-1:0] expo;
    logic [MAN_W+3:0] man_a;
    logic [MAN_W+3:0] man_b;
    fp_class_e        cls_a;
    fp_class_e        cls_b;
    logic             rnd;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W+4:0] sum;
    spc_e             spc;
    logic             spc_sign;
    logic             rnd;
  } s2_t;

  // Subnormals fall into ZERO: the datapath flushes them
  function automatic fp_class_e fp_class(input logic [31:0] x);
    if (x[30:23] == '0)     return ZERO;
    if (x[30:23] == EXP_MAX) return (x[22:0] != '0) ? NAN : INF;
    return NORM;
  endfunction
endpackage

// File: rtl/fpu_lzc28.sv
// Leading-zero count over 28 bits; an all-zero input reports 28.
module fpu_lzc28 (
  input  logic [27:0] din,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++)
      if (din[i]) cnt = 5'(27 - i);
  end
endmodule

// File: rtl/fpu_add_sub_pipe.sv
// Three-stage binary32 add/sub (align, add, normalise/round) with a single
// global stall driven by output backpressure.
module fpu_add_sub_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int FTZ   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_add_sub,
  input  logic             i_rnd,
  input  logic [31:0]      i_32_a,
  input  logic [31:0]      i_32_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_32_s,
  output logic [TAG_W-1:0] o_tag,
  output logic [2:0]       o_flags
);
  localparam int STAGES = 3;

  if (FTZ != 1) begin : g_ftz_only
  end

  logic              en;
  logic [STAGES-1:0] vld_pipe;
  logic [TAG_W-1:0]  tag_s1, tag_s2;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;

  assign en      = ~o_valid | i_ready;
  assign o_ready = en;
  assign o_valid = vld_pipe[STAGES-1];

  // S1: classify, order by magnitude, align the smaller operand
  fp_class_e   ca, cb, c_big, c_sml;
  logic        sb_eff, swap;
  logic [30:0] mag_a, mag_b;
  logic [31:0] big, sml;
  logic [23:0] m_sml;
  logic [7:0]  dexp;
  logic [53:0] ext;

  always_comb begin
    sb_eff = i_32_b[31] ^ i_add_sub;
    ca     = fp_class(i_32_a);
    cb     = fp_class(i_32_b);
    mag_a  = (ca == ZERO) ? '0 : i_32_a[30:0];
    mag_b  = (cb == ZERO) ? '0 : i_32_b[30:0];
    swap   = mag_b > mag_a;
    big    = swap ? {sb_eff, i_32_b[30:0]} : i_32_a;
    sml    = swap ? i_32_a : {sb_eff, i_32_b[30:0]};
    c_big  = swap ? cb : ca;
    c_sml  = swap ? ca : cb;
    m_sml  = (c_sml == NORM) ? {1'b1, sml[22:0]} : '0;
    dexp   = big[30:23] - sml[30:23];
    ext    = {m_sml, 3'b000, 27'd0} >> dexp;

    s1_d.sign_a = big[31];
    s1_d.sign_b = sml[31];
    s1_d.expo   = big[30:23];
    s1_d.man_a  = (c_big == NORM) ? {1'b1, big[22:0], 3'b000} : '0;
    s1_d.man_b  = (dexp >= 8'd27) ? {26'd0, |m_sml}
                                  : ext[53:27] | {26'd0, |ext[26:0]};
    s1_d.cls_a  = c_big;
    s1_d.cls_b  = c_sml;
    s1_d.rnd    = i_rnd;
  end

  // S2: magnitude add/subtract and special-case decode
  logic eq_sign;

  always_comb begin
    eq_sign       = s1_q.sign_a == s1_q.sign_b;
    s2_d.sign     = s1_q.sign_a;
    s2_d.expo     = s1_q.expo;
    s2_d.rnd      = s1_q.rnd;
    s2_d.sum      = eq_sign ? {1'b0, s1_q.man_a} + {1'b0, s1_q.man_b}
                            : {1'b0, s1_q.man_a} - {1'b0, s1_q.man_b};
    s2_d.spc      = SPC_NONE;
    s2_d.spc_sign = s1_q.sign_a;
    // B can only be infinite when A is too, so A's class decides inf results
    if (s1_q.cls_a == NAN || s1_q.cls_b == NAN ||
        (s1_q.cls_a == INF && s1_q.cls_b == INF && !eq_sign))
      s2_d.spc = SPC_NAN;
    else if (s1_q.cls_a == INF)
      s2_d.spc = SPC_INF;
    else if (s2_d.sum == '0) begin
      s2_d.spc      = SPC_ZERO;
      s2_d.spc_sign = s1_q.sign_a & s1_q.sign_b;
    end
  end

  // S3: normalise, round, pack
  logic [4:0]  lz;
  logic [26:0] shl, m;
  logic [9:0]  e, e_f;
  logic        up, ovf, unf;
  logic [24:0] mr;
  logic [22:0] frac;
  logic [31:0] res_d;
  logic [2:0]  flags_d;

  fpu_lzc28 u_lzc (.din(s2_q.sum), .cnt(lz));

  always_comb begin
    shl = s2_q.sum[26:0] << (lz - 5'd1);
    if (s2_q.sum[27]) begin
      m = {s2_q.sum[27:2], |s2_q.sum[1:0]};
      e = {2'b00, s2_q.expo} + 10'd1;
    end else begin
      // hidden bit sits at sum[26], so one leading zero means already normal
      m = shl;
      e = {2'b00, s2_q.expo} - {5'd0, lz} + 10'd1;
    end
    up   = ~s2_q.rnd & m[2] & (m[1] | m[0] | m[3]);
    mr   = {1'b0, m[26:3]} + {24'd0, up};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    e_f  = e + {9'd0, mr[24]};
    ovf  = ~e_f[9] & (e_f >= 10'd255);
    unf  = e_f[9] | (e_f == 10'd0);

    flags_d = 3'b000;
    case (s2_q.spc)
      SPC_NAN: begin
        res_d   = QNAN;
        flags_d = 3'b100;
      end
      SPC_INF:  res_d = {s2_q.spc_sign, EXP_MAX, 23'd0};
      SPC_ZERO: res_d = {s2_q.spc_sign, 31'd0};
      default: begin
        if (ovf) begin
          res_d   = s2_q.rnd ? {s2_q.sign, MAXF[30:0]} : {s2_q.sign, EXP_MAX, 23'd0};
          flags_d = 3'b010;
        end else if (unf) begin
          res_d   = {s2_q.sign, 31'd0};
          flags_d = 3'b001;
        end else
          res_d = {s2_q.sign, e_f[7:0], frac};
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      tag_s1   <= '0;
      tag_s2   <= '0;
      o_32_s   <= '0;
      o_tag    <= '0;
      o_flags  <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], i_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      tag_s1   <= i_tag;
      tag_s2   <= tag_s1;
      o_32_s   <= res_d;
      o_tag    <= tag_s2;
      o_flags  <= flags_d;
    end
  end
endmodule
